tsip_timing_tx: RTL and testbench
=================================

# tsip_timing_tx

Generates TSIP 0x8F-AB timing packets over UART once per second, acting as the Thunderbolt side of the link. It keeps its own time-of-week and time-of-day counters, emits a one-cycle PPS, then serializes a DLE-framed, byte-stuffed packet into the existing `uart_tx` byte handshake. It lets the `thunderbolt` receiver and the downstream pulse generators be tested on hardware and in simulation without a GPS receiver.

## Interface
- `CLKS_PER_SEC`, 10_000_000, clock cycles per second (10 MHz clock).
- `UTC_OFFSET`, 16'd18, GPS-UTC offset field, signed, sent verbatim.
- `TIMING_FLAG`, 8'h03, timing flag byte: UTC time, UTC PPS.
- `i_clk` in 1, system clock.
- `i_rst_n` in 1, reset. Asynchronous assert, active-low.
- `i_load` in 1, one-cycle pulse that loads all time inputs.
- `i_tow` in 32, time of week in seconds, 0..604799.
- `i_week` in 16, GPS week number.
- `i_year` in 16, year.
- `i_month` in 8, month, 1..12.
- `i_day` in 8, day, 1..31.
- `i_hour` in 8, hour.
- `i_minutes` in 8, minutes.
- `i_seconds` in 8, seconds.
- `o_pps` out 1, one-cycle second tick.
- `o_tx_dv` out 1, one-cycle request to `uart_tx`.
- `o_tx_byte` out 8, byte to send. Stable from the `o_tx_dv` cycle until `i_tx_done`.
- `i_tx_done` in 1, one-cycle done strobe from `uart_tx`.
- `o_busy` out 1, packet in progress.
- `o_overrun` out 1, one-cycle pulse when a second's packet is skipped.

## Operation
- **Prescaler** counts 0..CLKS_PER_SEC-1. On the wrap cycle, `o_pps` is registered high for one cycle and all time counters advance by one second.
- **Advance rules:**
  - `tow` wraps from 604799 to 0 and increments `week`; `week` wraps at 16 bits.
  - `seconds` wraps at 59 into `minutes`, `minutes` wraps at 59 into `hour`, and `hour` wraps at 23 into the date (see Configuration).
- **Load:** `i_load` loads every counter and clears the prescaler to 0. No packet is sent on load. If `i_load` and the wrap coincide, `i_load` wins and there is no `o_pps`.
- **Snapshot:** the cycle after `o_pps`, the advanced time is copied into the packet snapshot if FSM is IDLE. Otherwise `o_overrun` pulses and that second is skipped.
- **Packet, before stuffing (21 bytes):** DLE, 8F, AB, tow[31:0] MSB first, week[15:0], UTC_OFFSET[15:0], TIMING_FLAG, seconds, minutes, hour, day, month, year[15:8], year[7:0], DLE, ETX.
- **Stuffing:** each byte from AB through year[7:0] that equals 0x10 is sent twice. Header DLE and trailer DLE/ETX are never stuffed.
- **FSM states:**
  - IDLE: on snapshot go to SEND, index=0.
  - SEND: `o_tx_dv`=1 for one cycle, go to WAIT.
  - WAIT: on `i_tx_done`, if the byte was a payload 0x10 and not yet repeated, go to STUFF. Else if index==20, go to IDLE. Else index++ and go to SEND.
  - STUFF: `o_tx_dv`=1 with 0x10, go to WAIT with the repeat mark set.
- `o_busy` is high in every state except IDLE.
- **Reset values:** `o_pps`, `o_tx_dv`, `o_busy` and `o_overrun` are 0; `o_tx_byte`=8'h10; time is 2000-01-01 00:00:00; `tow`=0; `week`=0; prescaler=0; FSM=IDLE.
- **Reset mid-packet:** all outputs are forced to reset values immediately. No partial packet resumes.

## Timing
- `o_pps` is high in cycle N.
- Snapshot is taken at N+1.
- First `o_tx_dv` is at N+2.
- Each following `o_tx_dv` comes one cycle after the previous `i_tx_done`.
- `i_tx_done` outside WAIT is ignored.
- `o_overrun` is high in cycle N+1 when a packet is skipped.

## Configuration
- Macro `TSIP_CALENDAR_EN`.
- **Defined:** the hour wrap advances `day` using month lengths. February has 29 days when year[1:0]==0 (valid for 1901-2099). The day wrap increments `month`, and the month-12 wrap sets `month`=1 and increments `year`.
- **Undefined:** the hour wrap goes 23→0 and `day`, `month` and `year` hold their loaded values.

## Structure
- Package `tsip_pkg` holds:
  - constants: DLE 8'h10, ETX 8'h03, TIM_ID 8'h8F, TIM_SUBCODE 8'hAB, TIM_PACKET_BYTES 21, SECONDS_PER_WEEK 604800;
  - the FSM state enum.
- One sub-module, `tsip_time_counter`, holds the tow/week/hh:mm:ss/calendar counters, the load logic and the `TSIP_CALENDAR_EN` logic.
- The top level keeps the prescaler, snapshot, byte mux and FSM.

## Test plan
- **Calendar rollover:** with `TSIP_CALENDAR_EN`, CLKS_PER_SEC=100, load 2024-02-28 23:59:59 with tow=1000 and week=2300. Required: `o_pps` at prescaler wrap; bytes 10 8F AB 00 00 03 E9 08 FC 00 12 03 00 00 00 1D 02 07 E8 10 03, with `o_tx_dv` first at N+2.
- **Stuffing:** load seconds=15, so the packet carries seconds=0x10. Required: 22 bytes with 10 10 at the seconds position, and the `thunderbolt` receiver outputs `o_thunder_seconds`=0x10.
- **Calendar compiled out:** without the macro, load 2024-12-31 23:59:59. Required: packet hour 00, day 1F, month 0C, year 07 E8.
- **TOW wrap:** load tow=604799, week=5. Required: packet tow 00 00 00 00, week 00 06.
- **Overrun:** hold `i_tx_done` low beyond one second. Required: `o_overrun` pulses at N+1 of the next `o_pps`, and no second header DLE appears mid-packet.
- **Reset mid-packet:** assert `i_rst_n` low at byte 7. Required: `o_tx_dv`=0 and `o_busy`=0 asynchronously, and after release the first packet follows the first `o_pps`.

Source files
------------

// File: rtl/tsip_pkg.sv
// Shared constants, FSM state and time record for the TSIP 0x8F-AB timing transmitter.
package tsip_pkg;

  localparam logic [7:0]  DLE              = 8'h10;
  localparam logic [7:0]  ETX              = 8'h03;
  localparam logic [7:0]  TIM_ID           = 8'h8F;
  localparam logic [7:0]  TIM_SUBCODE      = 8'hAB;
  localparam int          TIM_PACKET_BYTES = 21;
  localparam logic [31:0] SECONDS_PER_WEEK = 32'd604800;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_STUFF
  } tx_state_e;

  typedef struct packed {
    logic [31:0] tow;
    logic [15:0] week;
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } tsip_time_t;

  // Leap rule year%4==0 holds for 1901-2099.
  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    case (month)
      8'd2:                    days_in_month = leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
      default:                 days_in_month = 8'd31;
    endcase
  endfunction

endpackage

// File: rtl/tsip_time_counter.sv
// Time-of-week / time-of-day counters; advance one second per i_tick, i_load wins over i_tick.
// Latency: one cycle from i_tick or i_load to o_time. No backpressure.
// Macro TSIP_CALENDAR_EN enables day/month/year rollover on the hour wrap.
module tsip_time_counter
  import tsip_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  tsip_time_t i_time,
  input  logic       i_tick,
  output tsip_time_t o_time
);

  tsip_time_t nxt;

  always_comb begin
    nxt = o_time;
    if (o_time.tow >= SECONDS_PER_WEEK - 32'd1) begin
      nxt.tow  = 32'd0;
      nxt.week = o_time.week + 16'd1;
    end else begin
      nxt.tow = o_time.tow + 32'd1;
    end

    if (o_time.seconds >= 8'd59) begin
      nxt.seconds = 8'd0;
      if (o_time.minutes >= 8'd59) begin
        nxt.minutes = 8'd0;
        if (o_time.hour >= 8'd23) begin
          nxt.hour = 8'd0;
`ifdef TSIP_CALENDAR_EN
          if (o_time.day >= days_in_month(o_time.month, o_time.year[1:0] == 2'b00)) begin
            nxt.day = 8'd1;
            if (o_time.month >= 8'd12) begin
              nxt.month = 8'd1;
              nxt.year  = o_time.year + 16'd1;
            end else begin
              nxt.month = o_time.month + 8'd1;
            end
          end else begin
            nxt.day = o_time.day + 8'd1;
          end
`else
          // Date holds its loaded value when the calendar is compiled out.
          nxt.day = o_time.day;
`endif
        end else begin
          nxt.hour = o_time.hour + 8'd1;
        end
      end else begin
        nxt.minutes = o_time.minutes + 8'd1;
      end
    end else begin
      nxt.seconds = o_time.seconds + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_time <= '{tow: 32'd0, week: 16'd0, year: 16'd2000, month: 8'd1, day: 8'd1,
                  hour: 8'd0, minutes: 8'd0, seconds: 8'd0};
    end else if (i_load) begin
      o_time <= i_time;
    end else if (i_tick) begin
      o_time <= nxt;
    end
  end

endmodule

// File: rtl/tsip_timing_tx.sv
// Once-per-second TSIP 0x8F-AB packet generator driving a uart_tx byte handshake.
// Latency: o_pps at N, first o_tx_dv at N+2, each next o_tx_dv one cycle after i_tx_done.
// Backpressure: waits on i_tx_done per byte; a second arriving mid-packet is skipped (o_overrun). Macro: TSIP_CALENDAR_EN.
module tsip_timing_tx
  import tsip_pkg::*;
#(
  parameter int          CLKS_PER_SEC = 10_000_000,
  parameter logic [15:0] UTC_OFFSET   = 16'd18,
  parameter logic [7:0]  TIMING_FLAG  = 8'h03
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_tow,
  input  logic [15:0] i_week,
  input  logic [15:0] i_year,
  input  logic [7:0]  i_month,
  input  logic [7:0]  i_day,
  input  logic [7:0]  i_hour,
  input  logic [7:0]  i_minutes,
  input  logic [7:0]  i_seconds,
  output logic        o_pps,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int              PW        = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLKS_PER_SEC - 1);
  localparam logic [4:0]      LAST_IDX  = 5'(TIM_PACKET_BYTES - 1);

  logic [PW-1:0] presc;
  logic          wrap;
  logic          tick;
  logic          snap_go;
  tsip_time_t    load_time;
  tsip_time_t    cur_time;
  tsip_time_t    snap;
  tx_state_e     state;
  logic [4:0]    idx;
  logic [4:0]    byte_sel;
  logic          rep;
  logic [7:0]    next_byte;
  logic          stuff_needed;

  assign wrap = (presc == PRESC_MAX);
  assign tick = wrap && !i_load;

  assign load_time = '{tow: i_tow, week: i_week, year: i_year, month: i_month, day: i_day,
                       hour: i_hour, minutes: i_minutes, seconds: i_seconds};

  tsip_time_counter u_time (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_load),
    .i_time  (load_time),
    .i_tick  (tick),
    .o_time  (cur_time)
  );

  // Snapshot/overrun decision is made once, on the o_pps cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc     <= '0;
      o_pps     <= 1'b0;
      snap_go   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      presc     <= (i_load || wrap) ? '0 : presc + PW'(1);
      o_pps     <= tick;
      snap_go   <= o_pps && (state == ST_IDLE);
      o_overrun <= o_pps && (state != ST_IDLE);
    end
  end

  assign byte_sel = idx + 5'd1;

  always_comb begin
    next_byte = DLE;
    case (byte_sel)
      5'd1:    next_byte = TIM_ID;
      5'd2:    next_byte = TIM_SUBCODE;
      5'd3:    next_byte = snap.tow[31:24];
      5'd4:    next_byte = snap.tow[23:16];
      5'd5:    next_byte = snap.tow[15:8];
      5'd6:    next_byte = snap.tow[7:0];
      5'd7:    next_byte = snap.week[15:8];
      5'd8:    next_byte = snap.week[7:0];
      5'd9:    next_byte = UTC_OFFSET[15:8];
      5'd10:   next_byte = UTC_OFFSET[7:0];
      5'd11:   next_byte = TIMING_FLAG;
      5'd12:   next_byte = snap.seconds;
      5'd13:   next_byte = snap.minutes;
      5'd14:   next_byte = snap.hour;
      5'd15:   next_byte = snap.day;
      5'd16:   next_byte = snap.month;
      5'd17:   next_byte = snap.year[15:8];
      5'd18:   next_byte = snap.year[7:0];
      5'd20:   next_byte = ETX;
      default: next_byte = DLE;
    endcase
  end

  // Only bytes from the subcode through year[7:0] are stuffed.
  assign stuff_needed = (idx >= 5'd2) && (idx <= 5'd18) && (o_tx_byte == DLE) && !rep;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      idx       <= 5'd0;
      rep       <= 1'b0;
      snap      <= '0;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= DLE;
      o_busy    <= 1'b0;
    end else begin
      o_tx_dv <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (snap_go) begin
            snap      <= cur_time;
            idx       <= 5'd0;
            rep       <= 1'b0;
            o_tx_byte <= DLE;
            o_tx_dv   <= 1'b1;
            o_busy    <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: state <= ST_WAIT;
        ST_STUFF: begin
          rep   <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            if (stuff_needed) begin
              o_tx_dv <= 1'b1;
              state   <= ST_STUFF;
            end else if (idx == LAST_IDX) begin
              o_busy <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              idx       <= byte_sel;
              rep       <= 1'b0;
              o_tx_byte <= next_byte;
              o_tx_dv   <= 1'b1;
              state     <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsip_timing_tx.sv
// Directed bench for tsip_timing_tx with a small uart_tx responder; expected packets are hand-computed.
module tb_tsip_timing_tx;

  localparam int CPS = 100;

`ifdef TSIP_CALENDAR_EN
  localparam logic [7:0]  DAY1 = 8'h1D;
  localparam logic [31:0] DMY3 = 32'h01_01_07_E9;
`else
  localparam logic [7:0]  DAY1 = 8'h1C;
  localparam logic [31:0] DMY3 = 32'h1F_0C_07_E8;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_load = 1'b0;
  logic [31:0] i_tow = '0;
  logic [15:0] i_week = '0;
  logic [15:0] i_year = '0;
  logic [7:0]  i_month = '0, i_day = '0, i_hour = '0, i_minutes = '0, i_seconds = '0;
  logic        i_tx_done = 1'b0;
  logic        o_pps, o_tx_dv, o_busy, o_overrun;
  logic [7:0]  o_tx_byte;

  tsip_timing_tx #(.CLKS_PER_SEC(CPS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load),
    .i_tow(i_tow), .i_week(i_week), .i_year(i_year), .i_month(i_month), .i_day(i_day),
    .i_hour(i_hour), .i_minutes(i_minutes), .i_seconds(i_seconds),
    .o_pps(o_pps), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: accepts a byte on o_tx_dv, answers i_tx_done after lat cycles.
  logic [7:0] rx_q[$];
  int         dv_cyc[$];
  int         lat = 1;
  int         last_done = -1000;
  int         gap_err = 0;
  int         stab_err = 0;
  logic [7:0] hold_b;

  initial begin : uart_model
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (o_tx_dv) begin
        if ((cyc - last_done) < 10 && (cyc - last_done) != 1) gap_err++;
        hold_b = o_tx_byte;
        rx_q.push_back(hold_b);
        dv_cyc.push_back(cyc);
        repeat (lat) begin
          @(negedge i_clk);
          if (o_tx_byte !== hold_b && i_rst_n) stab_err++;
        end
        i_tx_done = 1'b1;
        last_done = cyc;
      end
    end
  end

  int pps_cyc = -1;
  int ovr_cnt = 0;
  int ovr_gap = -1;

  initial begin : monitor
    forever begin
      @(negedge i_clk);
      if (o_pps) pps_cyc = cyc;
      if (o_overrun) begin
        ovr_cnt++;
        ovr_gap = cyc - pps_cyc;
      end
    end
  end

  int load_cyc;

  task automatic do_load(input logic [31:0] tow, input logic [15:0] week, input logic [15:0] year,
                         input logic [7:0] month, input logic [7:0] day, input logic [7:0] hour,
                         input logic [7:0] mins, input logic [7:0] secs);
    @(negedge i_clk);
    i_tow = tow; i_week = week; i_year = year; i_month = month; i_day = day;
    i_hour = hour; i_minutes = mins; i_seconds = secs;
    i_load = 1'b1;
    load_cyc = cyc;
    @(negedge i_clk);
    i_load = 1'b0;
  endtask

  task automatic wait_pps(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_pps && n < budget);
    check(tag, o_pps, 1'b1);
  endtask

  task automatic clear_q();
    rx_q.delete();
    dv_cyc.delete();
  endtask

  task automatic check_pkt(input string tag, input logic [255:0] vec, input int n, input int pps_at);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    check({tag, "_len"}, rx_q.size(), n);
    if (rx_q.size() < n) return;
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), rx_q[i], vec[(n-1-i)*8 +: 8]);
    check({tag, "_first_dv"}, dv_cyc[0] - pps_at, 2);
  endtask

  int n0;

  initial begin : stim
    // Reset values
    repeat (3) @(negedge i_clk);
    check("rst_pps", o_pps, 1'b0);
    check("rst_tx_dv", o_tx_dv, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_tx_byte", o_tx_byte, 8'h10);
    i_rst_n = 1'b1;

    // Hour wrap on 2024-02-28; day only rolls with the calendar built in
    do_load(32'd1000, 16'd2300, 16'd2024, 8'd2, 8'd28, 8'd23, 8'd59, 8'd59);
    wait_pps("pps1", 300);
    n0 = cyc;
    clear_q();
    check("pps_after_load", n0 - load_cyc, 101);
    @(negedge i_clk);
    check("busy_n1", o_busy, 1'b0);
    @(negedge i_clk);
    check("dv_n2", o_tx_dv, 1'b1);
    check("busy_n2", o_busy, 1'b1);
    check_pkt("cal", {72'h108FAB000003E908FC, 48'h001203000000, DAY1, 40'h0207E81003}, 21, n0);
    repeat (3) @(negedge i_clk);
    check("busy_end", o_busy, 1'b0);
    check("dv_end", o_tx_dv, 1'b0);

    // Free-running next second
    wait_pps("pps2", 300);
    check("pps_period", cyc - n0, CPS);
    n0 = cyc;
    clear_q();
    check_pkt("next", {72'h108FAB000003EA08FC, 48'h001203010000, DAY1, 40'h0207E81003}, 21, n0);

    // Stuffing: tow=0x1010 and seconds=0x10 after the advance
    do_load(32'h0000_100F, 16'd2301, 16'd2024, 8'd3, 8'd5, 8'd10, 8'd20, 8'd15);
    wait_pps("pps_stuff", 300);
    n0 = cyc;
    clear_q();
    check_pkt("stuff", 192'h108FAB0000101010_1008FD0012031010_140A050307E81003, 24, n0);

    // TOW wrap into next week plus year-end hour wrap
    do_load(32'd604799, 16'd5, 16'd2024, 8'd12, 8'd31, 8'd23, 8'd59, 8'd59);
    wait_pps("pps_wrap", 300);
    n0 = cyc;
    clear_q();
    check_pkt("wrap", {120'h108FAB000000000006001203000000, DMY3, 16'h1003}, 21, n0);

    // Overrun: first byte held longer than one second
    check("ovr_none_yet", ovr_cnt, 0);
    do_load(32'd200000, 16'd2310, 16'd2024, 8'd6, 8'd15, 8'd12, 8'd30, 8'd45);
    lat = 150;
    wait_pps("pps_ovr", 300);
    n0 = cyc;
    clear_q();
    for (int i = 0; i < 10 && rx_q.size() < 1; i++) @(negedge i_clk);
    lat = 1;
    check_pkt("ovr", 168'h108FAB00030D4109060012032E1E0C0F0607E81003, 21, n0);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_at_n1", ovr_gap, 1);

    // Reset in the middle of a packet
    do_load(32'd200000, 16'd2310, 16'd2024, 8'd6, 8'd15, 8'd12, 8'd30, 8'd45);
    wait_pps("pps_pre_rst", 300);
    clear_q();
    for (int i = 0; i < 100 && rx_q.size() < 7; i++) @(negedge i_clk);
    check("rst_reached_b7", rx_q.size(), 7);
    i_rst_n = 1'b0;
    #1;
    check("arst_tx_dv", o_tx_dv, 1'b0);
    check("arst_busy", o_busy, 1'b0);
    check("arst_tx_byte", o_tx_byte, 8'h10);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    load_cyc = cyc;
    @(negedge i_clk);
    clear_q();
    stab_err = 0;
    wait_pps("pps_post_rst", 300);
    n0 = cyc;
    check("pps_after_release", n0 - load_cyc, 100);
    check("no_partial_pkt", rx_q.size(), 0);
    check_pkt("post_rst", 168'h108FAB000000010000001203010000010107D01003, 21, n0);

    check("tx_byte_stable", stab_err, 0);
    check("dv_after_done_gap", gap_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
